// File: rtl/product_accumulator_if.sv
// Handshake bundle for product_accumulator: run control, product input stream and result output stream.
// slave = accumulator side, master = producer/sink side.
interface product_accumulator_if #(
    parameter int PROD_WIDTH  = 16,
    parameter int ACC_WIDTH   = 24,
    parameter int COUNT_WIDTH = 8
);
    logic                   start;
    logic [COUNT_WIDTH-1:0] length;
    logic                   prod_valid;
    logic                   prod_ready;
    logic [PROD_WIDTH-1:0]  product;
    logic                   acc_valid;
    logic                   acc_ready;
    logic [ACC_WIDTH-1:0]   acc_out;
    logic                   overflow;
    logic                   busy;

    modport slave (
        input  start, length, prod_valid, product, acc_ready,
        output prod_ready, acc_valid, acc_out, overflow, busy
    );

    modport master (
        output start, length, prod_valid, product, acc_ready,
        input  prod_ready, acc_valid, acc_out, overflow, busy
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums a run of unsigned products into a wide accumulator and hands the sum out over valid/ready.
// PRODUCT_ACCUMULATOR_SATURATE_EN: clamp to all-ones on carry instead of wrapping.
//
// state | meaning
// IDLE  | waiting for start; result of previous run still on acc_out
// ACCUM | accepting products until the run-length down-counter expires
// HOLD  | final sum presented on acc_out until the sink takes it
module product_accumulator #(
    parameter int PROD_WIDTH  = 16,
    parameter int ACC_WIDTH   = 24,
    parameter int COUNT_WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    product_accumulator_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                 state, state_nxt;
    logic [ACC_WIDTH-1:0]   acc, acc_nxt;
    logic                   ovf, ovf_nxt;
    logic [COUNT_WIDTH-1:0] remaining, remaining_nxt;
    logic [ACC_WIDTH:0]     prod_ext;
    logic [ACC_WIDTH:0]     sum;
    logic                   handshake;

    assign prod_ext  = {{(ACC_WIDTH + 1 - PROD_WIDTH){1'b0}}, bus.product};
    assign sum       = {1'b0, acc} + prod_ext;
    assign handshake = bus.prod_valid && (state == ACCUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            ovf       <= ovf_nxt;
            remaining <= remaining_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        ovf_nxt       = ovf;
        remaining_nxt = remaining;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_nxt       = '0;
                    ovf_nxt       = 1'b0;
                    remaining_nxt = bus.length;
                    state_nxt     = (bus.length == '0) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (handshake) begin
                    remaining_nxt = remaining - COUNT_WIDTH'(1);
                    if (sum[ACC_WIDTH])
                        ovf_nxt = 1'b1;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
                    // once clamped, later products must not pull the sum back down
                    acc_nxt = (sum[ACC_WIDTH] || ovf) ? '1 : sum[ACC_WIDTH-1:0];
`else
                    acc_nxt = sum[ACC_WIDTH-1:0];
`endif
                    if (remaining == COUNT_WIDTH'(1))
                        state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.acc_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.prod_ready = (state == ACCUM);
    assign bus.acc_valid  = (state == HOLD);
    assign bus.busy       = (state == ACCUM) || (state == HOLD);
    assign bus.acc_out    = acc;
    assign bus.overflow   = ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: a 24-bit instance for run/handshake behaviour and a
// 16-bit instance for carry handling (expected values follow PRODUCT_ACCUMULATOR_SATURATE_EN).
module tb_product_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    product_accumulator_if #(.PROD_WIDTH(16), .ACC_WIDTH(24), .COUNT_WIDTH(8)) bus ();
    product_accumulator_if #(.PROD_WIDTH(16), .ACC_WIDTH(16), .COUNT_WIDTH(8)) bus16 ();

    product_accumulator #(.PROD_WIDTH(16), .ACC_WIDTH(24), .COUNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));
    product_accumulator #(.PROD_WIDTH(16), .ACC_WIDTH(16), .COUNT_WIDTH(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(bus16.slave));

    int n_vec = 0;
    int n_err = 0;
    logic [24:0] exp_q[$];    // {overflow, acc_out}
    logic [16:0] exp16_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.acc_valid && bus.acc_ready) begin
            logic [24:0] e;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL result24_unexpected: got %h with no expected entry", {bus.overflow, bus.acc_out});
            end else begin
                e = exp_q.pop_front();
                if ({bus.overflow, bus.acc_out} !== e) begin
                    n_err++;
                    $display("FAIL result24: got ovf/acc %h expected %h at %0t", {bus.overflow, bus.acc_out}, e, $time);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus16.acc_valid && bus16.acc_ready) begin
            logic [16:0] e;
            n_vec++;
            if (exp16_q.size() == 0) begin
                n_err++;
                $display("FAIL result16_unexpected: got %h with no expected entry", {bus16.overflow, bus16.acc_out});
            end else begin
                e = exp16_q.pop_front();
                if ({bus16.overflow, bus16.acc_out} !== e) begin
                    n_err++;
                    $display("FAIL result16: got ovf/acc %h expected %h at %0t", {bus16.overflow, bus16.acc_out}, e, $time);
                end
            end
        end
    end

    task automatic do_start(input logic [7:0] len);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.length = len;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // returns #1 after the handshake edge
    task automatic send(input logic [15:0] p, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.prod_valid = 1'b1;
        bus.product    = p;
        t = 0;
        while (!bus.prod_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: prod_ready stayed %b, required 1", bus.prod_ready);
        end
        @(posedge clk);
        #1 bus.prod_valid = 1'b0;
    endtask

    task automatic do_start16(input logic [7:0] len);
        @(negedge clk);
        bus16.start  = 1'b1;
        bus16.length = len;
        @(posedge clk);
        #1 bus16.start = 1'b0;
    endtask

    task automatic send16(input logic [15:0] p);
        int t;
        @(negedge clk);
        bus16.prod_valid = 1'b1;
        bus16.product    = p;
        t = 0;
        while (!bus16.prod_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_vec++;
            n_err++;
            $display("FAIL send16_timeout: prod_ready stayed %b, required 1", bus16.prod_ready);
        end
        @(posedge clk);
        #1 bus16.prod_valid = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;   bus.length = '0;   bus.prod_valid = 1'b0;   bus.product = '0;   bus.acc_ready = 1'b1;
        bus16.start = 1'b0; bus16.length = '0; bus16.prod_valid = 1'b0; bus16.product = '0; bus16.acc_ready = 1'b1;

        #12;
        chk("reset_outputs", {bus.prod_ready, bus.acc_valid, bus.busy, bus.overflow, 8'h00, bus.acc_out}, 32'h0);
        chk("reset_outputs16", {bus16.prod_ready, bus16.acc_valid, bus16.busy, bus16.overflow, bus16.acc_out}, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // back-to-back run, result one cycle after last handshake
        exp_q.push_back({1'b0, 24'h0100FF});
        do_start(8'd3);
        chk("busy_after_start", {31'h0, bus.busy}, 32'h1);
        send(16'h0001, 0);
        send(16'h00FF, 0);
        chk("no_valid_mid_run", {31'h0, bus.acc_valid}, 32'h0);
        send(16'hFFFF, 0);
        chk("valid_latency", {31'h0, bus.acc_valid}, 32'h1);
        @(posedge clk); #1;
        chk("idle_after_accept", {30'h0, bus.acc_valid, bus.busy}, 32'h0);

        // gapped products, sink stalls in HOLD
        bus.acc_ready = 1'b0;
        exp_q.push_back({1'b0, 24'h0100FF});
        do_start(8'd3);
        send(16'h0001, 2);
        send(16'h00FF, 2);
        send(16'hFFFF, 2);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'h0, bus.acc_valid}, 32'h1);
            chk("hold_acc_stable", {8'h0, bus.acc_out}, 32'h0100FF);
            @(posedge clk); #1;
        end
        bus.acc_ready = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_stall", {30'h0, bus.acc_valid, bus.busy}, 32'h0);
        chk("acc_kept_in_idle", {8'h0, bus.acc_out}, 32'h0100FF);

        // empty run
        bus.acc_ready = 1'b0;
        exp_q.push_back({1'b0, 24'h000000});
        do_start(8'd0);
        chk("empty_run_hold", {30'h0, bus.acc_valid, bus.prod_ready}, 32'h2);
        chk("empty_run_acc", {8'h0, bus.acc_out}, 32'h0);
        bus.acc_ready = 1'b1;
        @(posedge clk); #1;

        // carry handling on the 16-bit instance
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
        exp16_q.push_back({1'b1, 16'hFFFF});
        exp16_q.push_back({1'b1, 16'hFFFF});
`else
        exp16_q.push_back({1'b1, 16'h0001});
        exp16_q.push_back({1'b1, 16'h0002});
`endif
        exp16_q.push_back({1'b0, 16'h0003});
        do_start16(8'd2);
        send16(16'hFFFF);
        send16(16'h0002);
        @(posedge clk); #1;
        do_start16(8'd3);
        send16(16'hFFFF);
        send16(16'h0002);
        send16(16'h0001);
        @(posedge clk); #1;
        do_start16(8'd1);
        send16(16'h0003);
        @(posedge clk); #1;

        // asynchronous reset mid-run
        do_start(8'd4);
        send(16'h0007, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {bus.prod_ready, bus.acc_valid, bus.busy, bus.overflow, 4'h0, bus.acc_out}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        exp_q.push_back({1'b0, 24'h000005});
        do_start(8'd1);
        send(16'h0005, 0);
        @(posedge clk); #1;

        // start while accumulating is ignored
        exp_q.push_back({1'b0, 24'h000030});
        do_start(8'd2);
        send(16'h0010, 0);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.length = 8'd9;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk("ignored_start_accum", {30'h0, bus.prod_ready, bus.acc_valid}, 32'h2);
        send(16'h0020, 1);
        chk("run_ends_after_two", {31'h0, bus.acc_valid}, 32'h1);
        @(posedge clk); #1;
        chk("idle_after_run6", {31'h0, bus.busy}, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue24_drained", exp_q.size(), 32'h0);
        chk("queue16_drained", exp16_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
        $fatal(1, "timeout");
    end

endmodule
